// File: rtl/axi_slv_rd_pkg.sv
// Shared AXI encodings plus the AR request record, FSM states and
// address-walk helpers used by the read-side slave responder.

`ifndef AXI_DEFINES_SVH
`define AXI_DEFINES_SVH
`define AXI_ID_WIDTH      4
`define AXI_ADDR_WIDTH    32
`define AXI_DATA_WIDTH    32
`define AXI_LEN_WIDTH     8
`define AXI_SIZE_WIDTH    3
`define AXI_BURST_WIDTH   2
`define AXI_RESP_WIDTH    2
`define AXI_USER_WIDTH    1
`define AXI_BURST_FIXED   2'b00
`define AXI_BURST_INCR    2'b01
`define AXI_BURST_WRAP    2'b10
`define AXI_BURST_RSVD    2'b11
`define AXI_RESP_OKAY     2'b00
`define AXI_RESP_EXOKAY   2'b01
`define AXI_RESP_SLVERR   2'b10
`define AXI_RESP_DECERR   2'b11
`define AXI_SIZE_1B       3'b000
`define AXI_SIZE_2B       3'b001
`define AXI_SIZE_4B       3'b010
`define AXI_SIZE_8B       3'b011
`define AXI_MAX_BURST_LEN 8
`endif

package axi_slv_rd_pkg;

  localparam int ID_W    = `AXI_ID_WIDTH;
  localparam int ADDR_W  = `AXI_ADDR_WIDTH;
  localparam int DATA_W  = `AXI_DATA_WIDTH;
  localparam int LEN_W   = `AXI_LEN_WIDTH;
  localparam int SIZE_W  = `AXI_SIZE_WIDTH;
  localparam int BURST_W = `AXI_BURST_WIDTH;
  localparam int RESP_W  = `AXI_RESP_WIDTH;
  localparam int USER_W  = `AXI_USER_WIDTH;

  localparam int MAX_BURST_LEN = `AXI_MAX_BURST_LEN;
  localparam int BYTE_SHIFT    = $clog2(DATA_W / 8);

  localparam logic [BURST_W-1:0] BURST_FIXED = `AXI_BURST_FIXED;
  localparam logic [BURST_W-1:0] BURST_INCR  = `AXI_BURST_INCR;
  localparam logic [BURST_W-1:0] BURST_WRAP  = `AXI_BURST_WRAP;
  localparam logic [BURST_W-1:0] BURST_RSVD  = `AXI_BURST_RSVD;

  localparam logic [RESP_W-1:0] RESP_OKAY   = `AXI_RESP_OKAY;
  localparam logic [RESP_W-1:0] RESP_SLVERR = `AXI_RESP_SLVERR;
  localparam logic [RESP_W-1:0] RESP_DECERR = `AXI_RESP_DECERR;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_req_t;

  // WRAP is only defined for 2, 4 or 8 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == LEN_W'(1)) || (len == LEN_W'(3)) || (len == LEN_W'(7));
  endfunction

  // Whole-burst SLVERR conditions.
  function automatic logic burst_is_illegal(input ar_req_t req);
    return (req.len > LEN_W'(MAX_BURST_LEN - 1)) ||
           (req.burst == BURST_RSVD) ||
           ((req.burst == BURST_WRAP) && !wrap_len_ok(req.len));
  endfunction

  // Addressing mode actually walked: reserved walks as FIXED, bad WRAP as INCR.
  function automatic logic [BURST_W-1:0] walk_mode(input ar_req_t req);
    if (req.burst == BURST_RSVD) return BURST_FIXED;
    if ((req.burst == BURST_WRAP) && !wrap_len_ok(req.len)) return BURST_INCR;
    return req.burst;
  endfunction

  // Byte address of the following beat.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0]  addr,
                                                  input logic [LEN_W-1:0]   len,
                                                  input logic [SIZE_W-1:0]  size,
                                                  input logic [BURST_W-1:0] mode);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wmask;
    incr  = ADDR_W'(1) << size;
    wmask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (mode)
      BURST_INCR: return addr + incr;
      BURST_WRAP: return (addr & ~wmask) | ((addr + incr) & wmask);
      default:    return addr;
    endcase
  endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a show-ahead head.
// Pushes while full and pops while empty are ignored.

module axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push;
  logic             do_pop;

  // Next pointers, occupancy and flags.
  always_comb begin
    // NOTE: combinational outputs are defaulted up front with blocking assignments so no path leaves them unassigned (no latch).
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately not reset; the pointers alone define which entries are valid.
    if (do_push) store_q[wr_ptr_q] <= wr_data;
  end

  assign head  = store_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/axi_slv_rd.sv
// AXI read slave: queues AR requests in order and replays each burst as R
// beats from a backdoor-loaded word memory, with SLVERR/DECERR per beat.

module axi_slv_rd
  import axi_slv_rd_pkg::*;
#(
  parameter int OST_DEPTH = 4,
  parameter int MEM_DEPTH = 256,
  localparam int MEM_AW = $clog2(MEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_W-1:0]    axi_slv_arid,
  input  logic [ADDR_W-1:0]  axi_slv_araddr,
  input  logic [LEN_W-1:0]   axi_slv_arlen,
  input  logic [SIZE_W-1:0]  axi_slv_arsize,
  input  logic [BURST_W-1:0] axi_slv_arburst,
  input  logic [USER_W-1:0]  axi_slv_aruser,
  input  logic               axi_slv_arvalid,
  output logic               axi_slv_arready,
  output logic [ID_W-1:0]    axi_slv_rid,
  output logic [DATA_W-1:0]  axi_slv_rdata,
  output logic [RESP_W-1:0]  axi_slv_rresp,
  output logic [USER_W-1:0]  axi_slv_ruser,
  output logic               axi_slv_rlast,
  output logic               axi_slv_rvalid,
  input  logic               axi_slv_rready,
  input  logic               mem_wr_en,
  input  logic [MEM_AW-1:0]  mem_wr_addr,
  input  logic [DATA_W-1:0]  mem_wr_data
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  ar_req_t ar_req;
  ar_req_t head;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_pop;
  logic    ar_push;

  rd_state_e          state_q, state_d;
  logic               init_q, init_d;
  logic [ADDR_W-1:0]  beat_addr_q, beat_addr_d;
  logic [LEN_W-1:0]   beats_left_q, beats_left_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic [BURST_W-1:0] mode_q, mode_d;
  logic               err_q, err_d;
  logic [ID_W-1:0]    rid_q, rid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [RESP_W-1:0]  rresp_q, rresp_d;
  logic               rlast_q, rlast_d;
  logic               rvalid_q, rvalid_d;

  logic              load;
  logic              advance;
  logic [ADDR_W-1:0] word_idx;
  logic              unused_aruser;

  // The user field carries nothing for this responder.
  assign unused_aruser = ^axi_slv_aruser;

  // arready depends only on registered flags; init_q holds it low through reset.
  assign axi_slv_arready = init_q & ~fifo_full;
  assign ar_push         = axi_slv_arvalid & axi_slv_arready;

  assign ar_req = '{id:    axi_slv_arid,
                    addr:  axi_slv_araddr,
                    len:   axi_slv_arlen,
                    size:  axi_slv_arsize,
                    burst: axi_slv_arburst};

  axi_sync_fifo #(
    .WIDTH ($bits(ar_req_t)),
    .DEPTH (OST_DEPTH)
  ) u_ar_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (ar_push),
    .wr_data (ar_req),
    .pop     (fifo_pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Backdoor load; a same-cycle read still sees the old word.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem_q[mem_wr_addr] <= mem_wr_data;
  end

  // Burst sequencing: pick the next beat and look up its payload.
  always_comb begin
    state_d      = state_q;
    init_d       = 1'b1;
    beat_addr_d  = beat_addr_q;
    beats_left_d = beats_left_q;
    len_d        = len_q;
    size_d       = size_q;
    mode_d       = mode_q;
    err_d        = err_q;
    rid_d        = rid_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rlast_d      = rlast_q;
    rvalid_d     = rvalid_q;
    fifo_pop     = 1'b0;
    load         = 1'b0;
    advance      = 1'b0;

    case (state_q)
      ST_IDLE: load = ~fifo_empty;
      ST_SEND: begin
        if (rvalid_q && axi_slv_rready) begin
          if (!rlast_q) begin
            advance = 1'b1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      fifo_pop     = 1'b1;
      state_d      = ST_SEND;
      rvalid_d     = 1'b1;
      rid_d        = head.id;
      beat_addr_d  = head.addr;
      beats_left_d = head.len;
      len_d        = head.len;
      size_d       = head.size;
      mode_d       = walk_mode(head);
      err_d        = burst_is_illegal(head);
      rlast_d      = (head.len == '0);
    end

    if (advance) begin
      beat_addr_d  = next_addr(beat_addr_q, len_q, size_q, mode_q);
      beats_left_d = beats_left_q - LEN_W'(1);
      rlast_d      = (beats_left_q == LEN_W'(1));
    end

    word_idx = beat_addr_d >> BYTE_SHIFT;
    if (load || advance) begin
      if (err_d) begin
        rresp_d = RESP_SLVERR;
        rdata_d = '0;
      end else if (word_idx >= ADDR_W'(MEM_DEPTH)) begin
        rresp_d = RESP_DECERR;
        rdata_d = '0;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = mem_q[word_idx[MEM_AW-1:0]];
      end
    end
  end

  // FSM, active-burst context and registered R outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      init_q       <= 1'b0;
      beat_addr_q  <= '0;
      beats_left_q <= '0;
      len_q        <= '0;
      size_q       <= '0;
      mode_q       <= BURST_FIXED;
      err_q        <= 1'b0;
      rid_q        <= '0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      rlast_q      <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_q       <= init_d;
      beat_addr_q  <= beat_addr_d;
      beats_left_q <= beats_left_d;
      len_q        <= len_d;
      size_q       <= size_d;
      mode_q       <= mode_d;
      err_q        <= err_d;
      rid_q        <= rid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rlast_q      <= rlast_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign axi_slv_rid    = rid_q;
  assign axi_slv_rdata  = rdata_q;
  assign axi_slv_rresp  = rresp_q;
  assign axi_slv_ruser  = '0;
  assign axi_slv_rlast  = rlast_q;
  assign axi_slv_rvalid = rvalid_q;

endmodule
